enqueue_agent_v0_2: RTL

Parametrised successor enqueue agent for the PIFO scheduler top. It decodes the sume_meta destination one-hot into per-queue enables for NUM_PHYS_PORTS physical queues plus one CPU/DMA queue. It gates each enable on buffer and PIFO fullness, then steers the packet beat by beat. Added over the previous generation: selectable multicast policy, correct single-beat packet handling, a per-packet frozen queue mask, and saturating statistics counters.

---
 rtl/enqueue_agent_v0_2.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/enqueue_agent_v0_2.sv
// Enqueue agent: decodes sume_meta destinations into per-queue enables, gates them on
// buffer/PIFO fullness once per packet, then steers every beat of the packet to that frozen mask.
module enqueue_agent_v0_2 #(
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PHYS_PORTS       = 4,
    parameter int DST_POS              = 24,
    parameter int DROP_POS             = 32,
    parameter int MCAST_MODE           = 0,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                            axis_aclk,
    input  logic                            axis_resetn,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic                            s_axis_tlast,
    input  logic                            s_axis_tpifo_valid,
    input  logic [NUM_PHYS_PORTS:0]         s_axis_buffer_almost_full,
    input  logic [NUM_PHYS_PORTS:0]         s_axis_pifo_full,
    output logic [NUM_PHYS_PORTS:0]         m_axis_ctl_pifo_in_en,
    output logic [NUM_PHYS_PORTS:0]         m_axis_ctl_buffer_wr_en,
    input  logic                            clr_stats,
    output logic [CNT_WIDTH-1:0]            stat_enq_pkt_cnt,
    output logic [CNT_WIDTH-1:0]            stat_drop_pkt_cnt,
    output logic [CNT_WIDTH-1:0]            stat_partial_mcast_cnt
);

    localparam int QUEUE_NUM = NUM_PHYS_PORTS + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        ENQ_SOP,
        ENQ_REMAIN,
        DROP
    } state_e;

    state_e               state_q, state_d;
    logic [QUEUE_NUM-1:0] mask_q, mask_d;
    logic [QUEUE_NUM-1:0] dst, avail;
    logic                 dropPkt;
    logic                 enqInc, dropInc, partialInc;
    logic [CNT_WIDTH-1:0] enqCnt_q, dropCnt_q, partialCnt_q;
    logic                 unusedTuserBits;

    assign unusedTuserBits = ^s_axis_tuser;

    // The CPU/DMA queue is wanted if any port's odd (DMA) bit is set.
    always_comb begin
        dst = '0;
        for (int i = 0; i < NUM_PHYS_PORTS; i++) begin
            dst[i]           = s_axis_tuser[DST_POS + 2*i];
            dst[QUEUE_NUM-1] = dst[QUEUE_NUM-1] | s_axis_tuser[DST_POS + 2*i + 1];
        end
    end

    assign avail   = dst & ~s_axis_buffer_almost_full & ~s_axis_pifo_full;
    assign dropPkt = s_axis_tuser[DROP_POS] | ~s_axis_tpifo_valid | (avail == '0)
                   | ((MCAST_MODE == 1) & (avail != dst));

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q <= IDLE;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        enqInc     = 1'b0;
        dropInc    = 1'b0;
        partialInc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s_axis_tvalid) begin
                    if (dropPkt) begin
                        state_d = DROP;
                        dropInc = 1'b1;
                    end else begin
                        state_d    = ENQ_SOP;
                        mask_d     = avail;
                        enqInc     = 1'b1;
                        partialInc = (avail != dst);
                    end
                end
            end
            ENQ_SOP: begin
                if (s_axis_tvalid) begin
                    state_d = s_axis_tlast ? IDLE : ENQ_REMAIN;
                end
            end
            ENQ_REMAIN, DROP: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready           = (state_q != IDLE);
        m_axis_ctl_pifo_in_en   = '0;
        m_axis_ctl_buffer_wr_en = '0;
        if (s_axis_tvalid) begin
            if (state_q == ENQ_SOP) begin
                m_axis_ctl_pifo_in_en   = mask_q;
                m_axis_ctl_buffer_wr_en = mask_q;
            end else if (state_q == ENQ_REMAIN) begin
                m_axis_ctl_buffer_wr_en = mask_q;
            end
        end
    end

    // Counters stick at all-ones; a clear beats an increment in the same cycle.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            enqCnt_q     <= '0;
            dropCnt_q    <= '0;
            partialCnt_q <= '0;
        end else if (clr_stats) begin
            enqCnt_q     <= '0;
            dropCnt_q    <= '0;
            partialCnt_q <= '0;
        end else begin
            if (enqInc && (enqCnt_q != '1)) begin
                enqCnt_q <= enqCnt_q + CNT_ONE;
            end
            if (dropInc && (dropCnt_q != '1)) begin
                dropCnt_q <= dropCnt_q + CNT_ONE;
            end
            if (partialInc && (partialCnt_q != '1)) begin
                partialCnt_q <= partialCnt_q + CNT_ONE;
            end
        end
    end

    assign stat_enq_pkt_cnt       = enqCnt_q;
    assign stat_drop_pkt_cnt      = dropCnt_q;
    assign stat_partial_mcast_cnt = partialCnt_q;

endmodule
